// File: rtl/muldiv_sequencer_if.sv
// rtl/muldiv_sequencer_if.sv - pipeline <-> HI/LO multiply/divide sequencer bundle
//
// Purpose: groups the op-issue handshake, the MFHI/MFLO read strobe and the
//          architectural HI/LO results into one bundle.
// Signals:
//   start        - a HI/LO-writing op is presented this cycle
//   op[2:0]      - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
//   rs, rt       - operands
//   hilo_rd      - pipeline executes MFHI/MFLO this cycle
//   busy         - multiply/divide in flight
//   stall        - combinational (start | hilo_rd) & busy
//   hi, lo       - architectural HI/LO
//   div_by_zero  - last accepted op was a divide by zero
// Modports: master = pipeline side, slave = sequencer side.
interface muldiv_sequencer_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        hilo_rd;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    modport master (
        output start, op, rs, rt, hilo_rd,
        input  busy, stall, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op, rs, rt, hilo_rd,
        output busy, stall, hi, lo, div_by_zero
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - 32-iteration shift-add multiplier / restoring divider owning HI/LO
//
// Purpose: accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO, runs 32 radix-2 iterations
//          plus one sign-fix/commit cycle, and stalls the pipeline while busy.
// Ports:
//   CLK  - clock, rising edge
//   RST  - asynchronous active-high reset
//   bus  - muldiv_sequencer_if.slave (see interface file for signal list)
module muldiv_sequencer (
    input  logic                 CLK,
    input  logic                 RST,
    muldiv_sequencer_if.slave    bus
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;          // multiplicand magnitude
    logic [31:0] b_q, b_d;          // multiplier / divisor magnitude
    logic [63:0] acc_q, acc_d;      // product, or {remainder, quotient}
    logic        neg_q, neg_d;      // product / quotient sign
    logic        neg_r_q, neg_r_d;  // remainder sign (dividend sign)
    logic        is_div_q, is_div_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        dbz_q, dbz_d;

    logic [31:0] rs_abs, rt_abs;
    logic        signed_op;
    logic [32:0] rem_sh;            // partial remainder after shifting in next dividend bit
    logic        rem_ge;
    logic [31:0] rem_sub;
    logic [63:0] res64;

    assign rs_abs = bus.rs[31] ? (~bus.rs + 32'd1) : bus.rs;
    assign rt_abs = bus.rt[31] ? (~bus.rt + 32'd1) : bus.rt;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        neg_d     = neg_q;
        neg_r_d   = neg_r_q;
        is_div_d  = is_div_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dbz_d     = dbz_q;
        signed_op = 1'b0;
        rem_sh    = acc_q[63:31];
        rem_ge    = 1'b0;
        rem_sub   = 32'd0;
        res64     = 64'd0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    dbz_d     = 1'b0;
                    signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
                    case (bus.op)
                        OP_MULT, OP_MULTU: begin
                            a_d      = signed_op ? rs_abs : bus.rs;
                            b_d      = signed_op ? rt_abs : bus.rt;
                            neg_d    = signed_op & (bus.rs[31] ^ bus.rt[31]);
                            neg_r_d  = 1'b0;
                            acc_d    = 64'd0;
                            cnt_d    = 5'd0;
                            is_div_d = 1'b0;
                            state_d  = S_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (bus.rt == 32'd0) begin
                                // Divide by zero: flag only, no busy period, HI/LO untouched.
                                dbz_d = 1'b1;
                            end else begin
                                acc_d    = {32'd0, (signed_op ? rs_abs : bus.rs)};
                                b_d      = signed_op ? rt_abs : bus.rt;
                                neg_d    = signed_op & (bus.rs[31] ^ bus.rt[31]);
                                neg_r_d  = signed_op & bus.rs[31];
                                cnt_d    = 5'd0;
                                is_div_d = 1'b1;
                                state_d  = S_DIV;
                            end
                        end
                        OP_MTHI: hi_d = bus.rs;
                        OP_MTLO: lo_d = bus.rs;
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                // Add partial product for multiplier bit cnt, weighted by 2^cnt.
                if (b_q[cnt_q])
                    acc_d = acc_q + ({32'd0, a_q} << cnt_q);
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    cnt_d   = 5'd0;
                    state_d = S_FIX;
                end
            end
            S_DIV: begin
                // Shift {rem,quot} left one; the remainder can briefly need 33 bits.
                rem_ge  = (rem_sh >= {1'b0, b_q});
                rem_sub = rem_sh[31:0] - b_q;
                acc_d   = {(rem_ge ? rem_sub : rem_sh[31:0]), acc_q[30:0], rem_ge};
                cnt_d   = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    cnt_d   = 5'd0;
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (is_div_q) begin
                    lo_d = neg_q   ? (~acc_q[31:0]  + 32'd1) : acc_q[31:0];
                    hi_d = neg_r_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
                end else begin
                    res64 = neg_q ? (~acc_q + 64'd1) : acc_q;
                    hi_d  = res64[63:32];
                    lo_d  = res64[31:0];
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            cnt_q    <= 5'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            acc_q    <= 64'd0;
            neg_q    <= 1'b0;
            neg_r_q  <= 1'b0;
            is_div_q <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            neg_r_q  <= neg_r_d;
            is_div_q <= is_div_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dbz_q    <= dbz_d;
        end
    end

    assign bus.busy        = (state_q != S_IDLE);
    assign bus.stall       = (bus.start | bus.hilo_rd) & bus.busy;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - directed self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;
    logic CLK;
    logic RST;
    int   n_cmp;
    int   n_err;
    int   n;

    muldiv_sequencer_if bus ();

    muldiv_sequencer dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
        bus.start = 1'b1;
        bus.op    = op;
        bus.rs    = rs;
        bus.rt    = rt;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (bus.busy && cycles < 40) begin
            cycles++;
            tick();
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        RST         = 1'b1;
        bus.start   = 1'b0;
        bus.op      = 3'd0;
        bus.rs      = 32'd0;
        bus.rt      = 32'd0;
        bus.hilo_rd = 1'b0;
        #12;
        chk("rst_hi",    bus.hi, 0);
        chk("rst_lo",    bus.lo, 0);
        chk("rst_busy",  bus.busy, 0);
        chk("rst_dbz",   bus.div_by_zero, 0);
        @(negedge CLK);
        RST = 1'b0;
        tick();

        // MTHI/MTLO then DIVU by zero
        issue(3'd4, 32'h11, 0);
        chk("mthi_hi", bus.hi, 32'h11);
        chk("mthi_busy", bus.busy, 0);
        issue(3'd5, 32'h22, 0);
        chk("mtlo_lo", bus.lo, 32'h22);
        issue(3'd3, 32'd5, 32'd0);
        chk("dbz_flag", bus.div_by_zero, 1);
        chk("dbz_busy", bus.busy, 0);
        tick();
        chk("dbz_busy2", bus.busy, 0);
        chk("dbz_hi", bus.hi, 32'h11);
        chk("dbz_lo", bus.lo, 32'h22);

        // MULT -3 * 5
        issue(3'd0, 32'hFFFFFFFD, 32'd5);
        chk("mult_dbz_clr", bus.div_by_zero, 0);
        chk("mult_hi_hold", bus.hi, 32'h11);
        wait_idle(n);
        chk("mult_cycles", n, 33);
        chk("mult_hi", bus.hi, 32'hFFFFFFFF);
        chk("mult_lo", bus.lo, 32'hFFFFFFF1);

        // MULTU max * max
        issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_idle(n);
        chk("multu_cycles", n, 33);
        chk("multu_hi", bus.hi, 32'hFFFFFFFE);
        chk("multu_lo", bus.lo, 32'h00000001);

        // DIV -7 / 2
        issue(3'd2, 32'hFFFFFFF9, 32'd2);
        wait_idle(n);
        chk("div_cycles", n, 33);
        chk("div_lo", bus.lo, 32'hFFFFFFFD);
        chk("div_hi", bus.hi, 32'hFFFFFFFF);

        // DIV 7 / -2
        issue(3'd2, 32'd7, 32'hFFFFFFFE);
        wait_idle(n);
        chk("div2_lo", bus.lo, 32'hFFFFFFFD);
        chk("div2_hi", bus.hi, 32'h00000001);

        // DIV overflow case 0x80000000 / -1
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(n);
        chk("divovf_lo", bus.lo, 32'h80000000);
        chk("divovf_hi", bus.hi, 32'h00000000);

        // DIVU 100 / 7
        issue(3'd3, 32'd100, 32'd7);
        wait_idle(n);
        chk("divu_lo", bus.lo, 32'd14);
        chk("divu_hi", bus.hi, 32'd2);

        // MFHI held across MULT 7 * -2: op accepted with read while idle, no stall
        bus.hilo_rd = 1'b1;
        bus.start   = 1'b1;
        bus.op      = 3'd0;
        bus.rs      = 32'd7;
        bus.rt      = 32'hFFFFFFFE;
        #1;
        chk("idle_nostall", bus.stall, 0);
        tick();
        bus.start = 1'b0;
        n = 0;
        while (bus.stall && n < 40) begin
            n++;
            tick();
        end
        chk("stall_cycles", n, 33);
        chk("stall_hi", bus.hi, 32'hFFFFFFFF);
        chk("stall_lo", bus.lo, 32'hFFFFFFF2);
        bus.hilo_rd = 1'b0;

        // back-to-back issue on first idle cycle
        issue(3'd1, 32'd3, 32'd4);
        chk("b2b_busy", bus.busy, 1);
        wait_idle(n);
        chk("b2b_cycles", n, 33);
        chk("b2b_lo", bus.lo, 32'd12);
        chk("b2b_hi", bus.hi, 32'd0);

        // start while busy is ignored, then async abort at iteration 10
        issue(3'd0, 32'd2, 32'd3);
        repeat (9) tick();
        bus.start = 1'b1;
        bus.op    = 3'd4;
        bus.rs    = 32'hDEADBEEF;
        #1;
        chk("busy_stall", bus.stall, 1);
        tick();
        chk("busy_ignored_hi", bus.hi, 32'd0);
        chk("busy_ignored_busy", bus.busy, 1);
        bus.start   = 1'b0;
        bus.hilo_rd = 1'b1;
        #2;
        RST = 1'b1;
        #1;
        chk("abort_busy",  bus.busy, 0);
        chk("abort_stall", bus.stall, 0);
        chk("abort_hi",    bus.hi, 0);
        chk("abort_lo",    bus.lo, 0);
        @(negedge CLK);
        RST = 1'b0;
        bus.hilo_rd = 1'b0;
        tick();
        issue(3'd5, 32'h55, 0);
        chk("post_rst_lo", bus.lo, 32'h55);
        chk("post_rst_busy", bus.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
